cnn_relu_maxpool: RTL and testbench

- Receive-side consumer of the conv core's output stream (core fmap bus plus its valid strobe).
- Applies ReLU per channel, then 2x2 stride-2 max pooling over the IX x IY raster-ordered feature map.
- Emits an (IX/2) x (IY/2) pooled stream per channel, one pooled word per output strobe.
- Sits directly downstream of the conv core and feeds the next layer or the FC stage.

---
 rtl/cnn_relu_maxpool.sv | 99 +++++++++
 tb/tb_cnn_relu_maxpool.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_relu_maxpool.sv
// ReLU + 2x2/stride-2 max pool over a raster-ordered IX x IY map, CO channels packed per word.
// Pooled word registered 1 cycle after its odd-row/odd-col pixel; no backpressure, input gaps allowed.
module cnn_relu_maxpool #(
  parameter int CO   = 3,
  parameter int I_BW = 23,
  parameter int IX   = 24,
  parameter int IY   = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_valid,
  input  logic [CO*I_BW-1:0]   i_fmap,
  output logic                 o_valid,
  output logic [CO*I_BW-1:0]   o_fmap,
  output logic                 o_frame_done
);

  localparam int LD = IX / 2;
  localparam int CW = (IX > 1) ? $clog2(IX) : 1;
  localparam int RW = (IY > 1) ? $clog2(IY) : 1;
  localparam int AW = (LD > 1) ? $clog2(LD) : 1;

  if ((IX % 2) != 0 || (IY % 2) != 0) begin : g_odd_dims
    $error("cnn_relu_maxpool: IX and IY must both be even");
  end

  typedef logic [CO-1:0][I_BW-1:0] chvec_t;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] lb_addr;
  logic          last_col;
  logic          last_row;
  chvec_t        hold;
  chvec_t        relu_v;
  chvec_t        pair_v;
  chvec_t        pool_v;
  chvec_t        lb_rd;
  chvec_t        linebuf [LD];

  function automatic logic [I_BW-1:0] umax(input logic [I_BW-1:0] a, input logic [I_BW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign lb_addr  = AW'(col >> 1);
  assign last_col = (col == CW'(IX - 1));
  assign last_row = (row == RW'(IY - 1));
  assign lb_rd    = linebuf[lb_addr];

  // After ReLU every value is non-negative, so unsigned compares give the signed max.
  always_comb begin
    relu_v = '0;
    pair_v = '0;
    pool_v = '0;
    for (int c = 0; c < CO; c++) begin
      relu_v[c] = i_fmap[c*I_BW + I_BW - 1] ? '0 : i_fmap[c*I_BW +: I_BW];
      pair_v[c] = umax(hold[c], relu_v[c]);
      pool_v[c] = umax(pair_v[c], lb_rd[c]);
    end
  end

  // Even rows park the horizontal pair max; the next odd row consumes it, so no clearing is needed.
  always_ff @(posedge clk) begin
    if (reset_n && i_valid && !row[0] && col[0]) begin
      linebuf[lb_addr] <= pair_v;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col          <= '0;
      row          <= '0;
      hold         <= '0;
      o_valid      <= 1'b0;
      o_fmap       <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_valid) begin
        if (!col[0]) begin
          hold <= relu_v;
        end
        if (row[0] && col[0]) begin
          o_valid      <= 1'b1;
          o_fmap       <= pool_v;
          o_frame_done <= last_row && last_col;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_relu_maxpool.sv
// Bench for cnn_relu_maxpool: drives frames, models pooling from a stored image, compares captured outputs.
module tb_cnn_relu_maxpool;

  localparam int CO   = 3;
  localparam int I_BW = 23;
  localparam int IX   = 24;
  localparam int IY   = 24;
  localparam int W    = CO * I_BW;
  localparam int NPIX = IX * IY;
  localparam int NOUT = (IX / 2) * (IY / 2);

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_valid = 1'b0;
  logic [W-1:0] i_fmap = '0;
  logic         o_valid;
  logic [W-1:0] o_fmap;
  logic         o_frame_done;

  cnn_relu_maxpool #(.CO(CO), .I_BW(I_BW), .IX(IX), .IY(IY)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_valid      (i_valid),
    .i_fmap       (i_fmap),
    .o_valid      (o_valid),
    .o_fmap       (o_fmap),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int           img [CO][IY][IX];
  logic [W-1:0] exp_q[$];
  bit           exp_done_q[$];
  int           acc_q[$];
  logic [W-1:0] got_q[$];
  bit           got_done_q[$];
  int           got_cyc_q[$];
  int           stray_done = 0;

  // Capture every output strobe on the falling edge, with the rising-edge index it followed.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      got_q.push_back(o_fmap);
      got_done_q.push_back(o_frame_done);
      got_cyc_q.push_back(cyc);
    end else if (o_frame_done !== 1'b0 && reset_n === 1'b1) begin
      stray_done++;
    end
  end

  function automatic int pixval(input int mode, input int ch, input int r, input int c);
    int v;
    case (mode)
      0: v = r * IX + c;
      1: v = -5;
      2: v = (ch == 0) ? r * IX + c : (ch == 1) ? -1 : ((r == 10 && c == 7) ? 1000 : 0);
      default: begin
        v = int'($urandom_range(0, (1 << I_BW) - 1));
        if (v >= (1 << (I_BW - 1))) v = v - (1 << I_BW);
      end
    endcase
    return v;
  endfunction

  function automatic logic [W-1:0] pack_same(input int v);
    logic [W-1:0] w;
    for (int ch = 0; ch < CO; ch++) w[ch*I_BW +: I_BW] = I_BW'(v);
    return w;
  endfunction

  task automatic clear_q();
    exp_q.delete(); exp_done_q.delete(); acc_q.delete();
    got_q.delete(); got_done_q.delete(); got_cyc_q.delete();
    stray_done = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_fmap  = W'({$urandom, $urandom, $urandom});
    end
  endtask

  // gap < 0 selects a random 0..3 idle cycles after each pixel.
  task automatic send_frame(input int mode, input int gap, input int npix);
    int n = 0;
    for (int r = 0; r < IY; r++) begin
      for (int c = 0; c < IX; c++) begin
        if (n < npix) begin
          logic [W-1:0] w;
          int ng;
          for (int ch = 0; ch < CO; ch++) begin
            img[ch][r][c] = pixval(mode, ch, r, c);
            w[ch*I_BW +: I_BW] = I_BW'(img[ch][r][c]);
          end
          @(negedge clk);
          i_valid = 1'b1;
          i_fmap  = w;
          if ((r % 2) == 1 && (c % 2) == 1) acc_q.push_back(cyc + 1);
          ng = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
          idle(ng);
          n++;
        end
      end
    end
    if (npix == NPIX) begin
      for (int pr = 0; pr < IY / 2; pr++) begin
        for (int pc = 0; pc < IX / 2; pc++) begin
          logic [W-1:0] w;
          for (int ch = 0; ch < CO; ch++) begin
            int m = 0;
            for (int d = 0; d < 4; d++) begin
              int v = img[ch][2*pr + d/2][2*pc + d%2];
              if (v > m) m = v;
            end
            w[ch*I_BW +: I_BW] = I_BW'(m);
          end
          exp_q.push_back(w);
          exp_done_q.push_back(pr == IY/2 - 1 && pc == IX/2 - 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_fmap  = W'({$urandom, $urandom, $urandom});
      checks++;
      if (o_valid !== 1'b0 || o_fmap !== '0 || o_frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b fmap=%h done=%b, need 0/0/0", o_valid, o_fmap, o_frame_done);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    i_valid = 1'b0;
  endtask

  task automatic test_ramp();
    clear_q();
    send_frame(0, 0, NPIX);
    idle(3);
    checks++;
    if (got_q.size() !== NOUT) begin
      errors++; $display("FAIL ramp_count: got %0d outputs, need %0d", got_q.size(), NOUT);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k] || got_done_q[k] !== exp_done_q[k] || got_cyc_q[k] !== acc_q[k]) begin
        errors++;
        $display("FAIL ramp_out[%0d]: got %h done=%b cyc=%0d, need %h done=%b cyc=%0d",
                 k, got_q[k], got_done_q[k], got_cyc_q[k], exp_q[k], exp_done_q[k], acc_q[k]);
      end
    end
    if (got_q.size() == NOUT) begin
      checks++;
      if (got_q[0] !== pack_same(25)) begin
        errors++; $display("FAIL ramp_first: got %h, need %h", got_q[0], pack_same(25));
      end
      checks++;
      if (got_q[NOUT-1] !== pack_same(575) || got_done_q[NOUT-1] !== 1'b1) begin
        errors++; $display("FAIL ramp_last: got %h done=%b, need %h done=1", got_q[NOUT-1], got_done_q[NOUT-1], pack_same(575));
      end
    end
    checks++;
    if (stray_done !== 0) begin
      errors++; $display("FAIL ramp_stray_done: got %0d stray pulses, need 0", stray_done);
    end
  endtask

  task automatic test_negative();
    clear_q();
    send_frame(1, 0, NPIX);
    idle(3);
    checks++;
    if (got_q.size() !== NOUT) begin
      errors++; $display("FAIL neg_count: got %0d outputs, need %0d", got_q.size(), NOUT);
    end
    for (int k = 0; k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== '0) begin
        errors++; $display("FAIL neg_out[%0d]: got %h, need 0", k, got_q[k]);
      end
    end
  endtask

  task automatic test_channels();
    clear_q();
    send_frame(2, 0, NPIX);
    idle(3);
    checks++;
    if (got_q.size() !== NOUT) begin
      errors++; $display("FAIL chan_count: got %0d outputs, need %0d", got_q.size(), NOUT);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL chan_out[%0d]: got %h, need %h", k, got_q[k], exp_q[k]);
      end
    end
    if (got_q.size() > 63) begin
      logic [W-1:0] w = got_q[63];
      checks++;
      if (w[2*I_BW +: I_BW] !== I_BW'(1000) || w[I_BW +: I_BW] !== '0) begin
        errors++; $display("FAIL chan_spot: got ch2=%0d ch1=%0d, need 1000/0", w[2*I_BW +: I_BW], w[I_BW +: I_BW]);
      end
    end
  endtask

  task automatic test_gapped();
    clear_q();
    send_frame(0, 2, NPIX);
    idle(3);
    checks++;
    if (got_q.size() !== NOUT) begin
      errors++; $display("FAIL gap_count: got %0d outputs, need %0d", got_q.size(), NOUT);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k] || got_done_q[k] !== exp_done_q[k] || got_cyc_q[k] !== acc_q[k]) begin
        errors++;
        $display("FAIL gap_out[%0d]: got %h done=%b cyc=%0d, need %h done=%b cyc=%0d",
                 k, got_q[k], got_done_q[k], got_cyc_q[k], exp_q[k], exp_done_q[k], acc_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    clear_q();
    send_frame(0, 0, 100);
    idle(2);
    clear_q();
    @(negedge clk);
    reset_n = 1'b0;
    i_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    i_valid = 1'b0;
    checks++;
    if (got_q.size() !== 0) begin
      errors++; $display("FAIL rstmid_quiet: got %0d outputs during reset, need 0", got_q.size());
    end
    reset_n = 1'b1;
    send_frame(0, 0, NPIX);
    idle(3);
    checks++;
    if (got_q.size() !== NOUT) begin
      errors++; $display("FAIL rstmid_count: got %0d outputs, need %0d", got_q.size(), NOUT);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      if (got_done_q[k]) ndone++;
      checks++;
      if (got_q[k] !== exp_q[k] || got_done_q[k] !== exp_done_q[k]) begin
        errors++; $display("FAIL rstmid_out[%0d]: got %h done=%b, need %h done=%b", k, got_q[k], got_done_q[k], exp_q[k], exp_done_q[k]);
      end
    end
    checks++;
    if (ndone !== 1 || stray_done !== 0) begin
      errors++; $display("FAIL rstmid_done: got %0d pulses (%0d stray), need 1", ndone, stray_done);
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    clear_q();
    send_frame(0, 0, NPIX);
    send_frame(0, 0, NPIX);
    idle(3);
    checks++;
    if (got_q.size() !== 2 * NOUT) begin
      errors++; $display("FAIL b2b_count: got %0d outputs, need %0d", got_q.size(), 2 * NOUT);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      if (got_done_q[k]) ndone++;
      checks++;
      if (got_q[k] !== exp_q[k] || got_done_q[k] !== exp_done_q[k] || got_cyc_q[k] !== acc_q[k]) begin
        errors++; $display("FAIL b2b_out[%0d]: got %h done=%b, need %h done=%b", k, got_q[k], got_done_q[k], exp_q[k], exp_done_q[k]);
      end
    end
    checks++;
    if (ndone !== 2 || stray_done !== 0) begin
      errors++; $display("FAIL b2b_done: got %0d pulses (%0d stray), need 2", ndone, stray_done);
    end
    if (got_q.size() > NOUT) begin
      checks++;
      if (got_q[NOUT] !== pack_same(25)) begin
        errors++; $display("FAIL b2b_second_first: got %h, need %h", got_q[NOUT], pack_same(25));
      end
    end
  endtask

  task automatic test_random();
    clear_q();
    send_frame(3, -1, NPIX);
    send_frame(3, 0, NPIX);
    idle(3);
    checks++;
    if (got_q.size() !== 2 * NOUT) begin
      errors++; $display("FAIL rand_count: got %0d outputs, need %0d", got_q.size(), 2 * NOUT);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k] || got_done_q[k] !== exp_done_q[k] || got_cyc_q[k] !== acc_q[k]) begin
        errors++;
        $display("FAIL rand_out[%0d]: got %h done=%b cyc=%0d, need %h done=%b cyc=%0d",
                 k, got_q[k], got_done_q[k], got_cyc_q[k], exp_q[k], exp_done_q[k], acc_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_channels();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
